// File: rtl/sha256_feeder.sv
// sha256_feeder
//   Accepts a byte-granular message as a stream of big-endian 32-bit words,
//   applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit length),
//   and feeds 16-word blocks to an external SHA-256 compression core.
//   Once the final block has been processed, it reads the 8-word digest back.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   in_valid/ready   upstream word handshake
//   in_data          message word, first byte in [31:24]
//   in_nbytes        valid bytes in in_data (0..4, 0 only with in_last)
//   in_last          final word of the message
//   core_rst         one-cycle core reset at message start
//   core_soc         one-cycle start-of-block pulse
//   core_idata       block word stream (word 0 the cycle after core_soc)
//   core_rd          digest read enable (8 cycles)
//   core_odata       digest word from core
//   core_eoc         core end-of-calculation
//   digest           final hash, H0 in [255:224]
//   digest_valid     one-cycle pulse when digest is updated
//   busy             high from first accepted word through digest_valid
//   err              sticky core timeout flag
module sha256_feeder #(
  parameter int unsigned EOC_TIMEOUT = 127
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_nbytes,
  input  logic         in_last,
  output logic         core_rst,
  output logic         core_soc,
  output logic [31:0]  core_idata,
  output logic         core_rd,
  input  logic [31:0]  core_odata,
  input  logic         core_eoc,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         err
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FILL  = 4'd1;
  localparam logic [3:0] S_PAD   = 4'd2;
  localparam logic [3:0] S_LEN   = 4'd3;
  localparam logic [3:0] S_WAITC = 4'd4;
  localparam logic [3:0] S_CRST  = 4'd5;
  localparam logic [3:0] S_SOC   = 4'd6;
  localparam logic [3:0] S_SEND  = 4'd7;
  localparam logic [3:0] S_WAITE = 4'd8;
  localparam logic [3:0] S_READ  = 4'd9;
  localparam logic [3:0] S_DONE  = 4'd10;

  logic [3:0]   r_state;
  logic [31:0]  r_buf [16];
  logic [4:0]   r_widx;     // next buffer word to write; 16 means block full
  logic [3:0]   r_sidx;     // word being sent
  logic [2:0]   r_ridx;     // digest word being read
  logic [63:0]  r_bytecnt;
  logic         r_first;    // core already reset for this message
  logic         r_pending;  // a sent block of this message is still computing
  logic         r_final;    // buffered block carries the length field
  logic         r_need80;   // 0x80 marker not yet placed (last word was full)
  logic         r_padding;  // message input ended; further blocks come from PAD
  logic [31:0]  r_tmo;
  logic         r_busy;
  logic         r_err;
  logic [255:0] r_digest;

  logic         w_xfer;
  logic [2:0]   w_nb;
  logic [31:0]  w_mask;
  logic [31:0]  w_mark;
  logic [31:0]  w_word;
  logic [63:0]  w_bitlen;
  logic         w_tmo_hit;

  assign in_ready     = (r_state == S_IDLE) || (r_state == S_FILL);
  assign w_xfer       = in_valid && in_ready;
  assign core_rst     = (r_state == S_CRST);
  assign core_soc     = (r_state == S_SOC);
  assign core_rd      = (r_state == S_READ);
  assign core_idata   = (r_state == S_SEND) ? r_buf[r_sidx] : '0;
  assign digest       = r_digest;
  assign digest_valid = (r_state == S_DONE);
  assign busy         = r_busy;
  assign err          = r_err;
  assign w_bitlen     = r_bytecnt << 3;

  // Out-of-range byte counts are treated as a full word.
  assign w_nb = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;

  always_comb begin
    w_mask = '1;
    w_mark = '0;
    case (w_nb)
      3'd0: begin w_mask = 32'h0000_0000; w_mark = 32'h8000_0000; end
      3'd1: begin w_mask = 32'hFF00_0000; w_mark = 32'h0080_0000; end
      3'd2: begin w_mask = 32'hFFFF_0000; w_mark = 32'h0000_8000; end
      3'd3: begin w_mask = 32'hFFFF_FF00; w_mark = 32'h0000_0080; end
      default: begin w_mask = 32'hFFFF_FFFF; w_mark = 32'h0000_0000; end
    endcase
  end

  assign w_word = (in_data & w_mask) | (in_last ? w_mark : 32'h0);

  // In WAITC the timer only matters while an earlier block is outstanding.
  assign w_tmo_hit = (r_tmo == EOC_TIMEOUT) && !core_eoc &&
                     (((r_state == S_WAITC) && r_pending) || (r_state == S_WAITE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      for (int unsigned i = 0; i < 16; i++) r_buf[i] <= '0;
      r_widx    <= '0;
      r_sidx    <= '0;
      r_ridx    <= '0;
      r_bytecnt <= '0;
      r_first   <= 1'b0;
      r_pending <= 1'b0;
      r_final   <= 1'b0;
      r_need80  <= 1'b0;
      r_padding <= 1'b0;
      r_tmo     <= '0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_digest  <= '0;
    end else begin
      if (core_eoc) r_pending <= 1'b0;

      case (r_state)
        S_IDLE, S_FILL: begin
          if (w_xfer) begin
            r_buf[r_widx[3:0]] <= w_word;
            r_widx    <= r_widx + 5'd1;
            r_bytecnt <= r_bytecnt + {61'd0, w_nb};
            r_busy    <= 1'b1;
            if (in_last) begin
              r_padding <= 1'b1;
              r_need80  <= (w_nb == 3'd4);
              r_state   <= S_PAD;
            end else if (r_widx == 5'd15) begin
              r_final <= 1'b0;
              r_tmo   <= '0;
              r_state <= S_WAITC;
            end else begin
              r_state <= S_FILL;
            end
          end
        end

        // One word per cycle: the pending 0x80 marker first, then zeros up to
        // word 14. If the marker lands in word 14 or 15 the block is closed with
        // zeros and the length goes into a further block.
        S_PAD: begin
          if (r_widx[4]) begin
            r_final <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_WAITC;
          end else if (r_need80) begin
            r_buf[r_widx[3:0]] <= 32'h8000_0000;
            r_need80 <= 1'b0;
            r_widx   <= r_widx + 5'd1;
          end else if (r_widx == 5'd14) begin
            r_state <= S_LEN;
          end else begin
            r_buf[r_widx[3:0]] <= '0;
            r_widx <= r_widx + 5'd1;
          end
        end

        S_LEN: begin
          r_buf[14]  <= w_bitlen[63:32];
          r_buf[15]  <= w_bitlen[31:0];
          r_widx     <= 5'd16;
          r_final    <= 1'b1;
          r_padding  <= 1'b0;
          r_tmo      <= '0;
          r_state    <= S_WAITC;
        end

        S_WAITC: begin
          if (!r_pending || core_eoc) begin
            r_pending <= 1'b0;
            r_state   <= r_first ? S_SOC : S_CRST;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end

        S_CRST: begin
          r_first <= 1'b1;
          r_state <= S_SOC;
        end

        S_SOC: begin
          r_sidx  <= '0;
          r_state <= S_SEND;
        end

        S_SEND: begin
          r_sidx <= r_sidx + 4'd1;
          if (r_sidx == 4'd15) begin
            r_pending <= 1'b1;
            r_widx    <= '0;
            r_tmo     <= '0;
            if (r_final)        r_state <= S_WAITE;
            else if (r_padding) r_state <= S_PAD;
            else                r_state <= S_FILL;
          end
        end

        S_WAITE: begin
          if (core_eoc) begin
            r_pending <= 1'b0;
            r_ridx    <= '0;
            r_state   <= S_READ;
          end else begin
            r_tmo <= r_tmo + 32'd1;
          end
        end

        S_READ: begin
          r_digest[{3'd7 - r_ridx, 5'd0} +: 32] <= core_odata;
          r_ridx <= r_ridx + 3'd1;
          if (r_ridx == 3'd7) r_state <= S_DONE;
        end

        S_DONE: begin
          r_bytecnt <= '0;
          r_first   <= 1'b0;
          r_pending <= 1'b0;
          r_final   <= 1'b0;
          r_need80  <= 1'b0;
          r_padding <= 1'b0;
          r_widx    <= '0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase

      // Core stopped responding: drop the message and return to idle.
      if (w_tmo_hit) begin
        r_err     <= 1'b1;
        r_state   <= S_IDLE;
        r_bytecnt <= '0;
        r_first   <= 1'b0;
        r_pending <= 1'b0;
        r_final   <= 1'b0;
        r_need80  <= 1'b0;
        r_padding <= 1'b0;
        r_widx    <= '0;
        r_busy    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_feeder.sv
// tb_sha256_feeder
//   Drives directed messages into sha256_feeder, backed by a behavioural
//   SHA-256 core. Expected block words and digests are queued by the stimulus
//   and compared by an independent monitor.
module tb_sha256_feeder;

  localparam int unsigned TMO = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_nbytes;
  logic         in_last;
  logic         core_rst;
  logic         core_soc;
  logic [31:0]  core_idata;
  logic         core_rd;
  logic [31:0]  core_odata;
  logic         core_eoc;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  sha256_feeder #(.EOC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_nbytes(in_nbytes), .in_last(in_last),
    .core_rst(core_rst), .core_soc(core_soc), .core_idata(core_idata),
    .core_rd(core_rd), .core_odata(core_odata), .core_eoc(core_eoc),
    .digest(digest), .digest_valid(digest_valid), .busy(busy), .err(err)
  );

  // ---------------- behavioural SHA-256 core ----------------
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  logic [255:0] m_h     = '0;
  logic [511:0] m_blk   = '0;
  int           m_widx  = -1;
  int           m_delay = 0;
  logic         m_eoc   = 1'b0;
  logic [2:0]   m_ridx  = '0;
  bit           eoc_kill = 1'b0;

  always @(posedge clk) begin
    if (core_soc) begin
      m_eoc  <= 1'b0;
      m_widx <= 0;
      m_ridx <= '0;
    end else if (m_widx >= 0 && m_widx < 16) begin
      m_blk[511 - 32*m_widx -: 32] <= core_idata;
      m_widx <= m_widx + 1;
      if (m_widx == 15) m_delay <= 12;
    end else if (m_widx == 16) begin
      if (m_delay == 0) begin
        m_h    <= sha_compress(m_h, m_blk);
        m_eoc  <= !eoc_kill;
        m_widx <= -1;
      end else begin
        m_delay <= m_delay - 1;
      end
    end
    if (core_rd) m_ridx <= m_ridx + 3'd1;
    if (core_rst) begin
      m_h    <= IV;
      m_eoc  <= 1'b0;
      m_widx <= -1;
      m_ridx <= '0;
    end
  end

  assign core_eoc   = m_eoc;
  assign core_odata = m_h[{3'd7 - m_ridx, 5'd0} +: 32];

  // ---------------- scoreboard ----------------
  typedef struct { bit chk; logic [255:0] d; } dig_t;

  logic [31:0] exp_words [$];
  dig_t        exp_dig [$];
  int n_vec = 0;
  int n_bad = 0;
  int n_soc = 0;
  int n_rst = 0;
  int n_dv  = 0;
  int n_acc = 0;
  bit ignore_words = 1'b0;
  int mon_idx = 16;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {255'd0, act}, {255'd0, exp});
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    check(name, 256'(act), 256'(exp));
  endtask

  task automatic push_blk(input logic [31:0] b [16]);
    for (int i = 0; i < 16; i++) exp_words.push_back(b[i]);
  endtask

  task automatic push_dig(input bit chk, input logic [255:0] d);
    dig_t e;
    e.chk = chk;
    e.d   = d;
    exp_dig.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    dig_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_idx = 16;
      end else begin
        if (core_rst) n_rst++;
        if (in_valid && in_ready) n_acc++;
        if (core_soc) begin
          n_soc++;
          mon_idx = 0;
        end else if (mon_idx < 16) begin
          if (!ignore_words) begin
            if (exp_words.size() == 0) begin
              n_vec++;
              n_bad++;
              $display("FAIL word%0d: got %h with no expected word queued", mon_idx, core_idata);
            end else begin
              check($sformatf("word%0d", mon_idx), {224'd0, core_idata}, {224'd0, exp_words.pop_front()});
            end
          end
          mon_idx++;
        end
        if (digest_valid) begin
          n_dv++;
          if (exp_dig.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL digest: got %h with no digest expected", digest);
          end else begin
            e = exp_dig.pop_front();
            if (e.chk) check("digest", digest, e.d);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = d; in_nbytes = nb; in_last = last;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    n_vec++;
    if (!in_ready) begin
      n_bad++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!digest_valid && !err && n < maxc) begin @(negedge clk); n++; end
    check1("digest_valid_seen", digest_valid, 1'b1);
  endtask

  task automatic wait_soc(input int maxc);
    int n;
    n = 0;
    while (!core_soc && n < maxc) begin @(negedge clk); n++; end
    check1("core_soc_seen", core_soc, 1'b1);
  endtask

  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_448 =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic [31:0] msg [14] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071
  };
  logic [31:0] blk [16];

  task automatic abc_block();
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  initial begin
    int acc0, dv0, cnt;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_nbytes = '0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_core_rst", core_rst, 1'b0);
    check1("rst_core_soc", core_soc, 1'b0);
    check1("rst_core_rd", core_rd, 1'b0);
    check("rst_core_idata", {224'd0, core_idata}, 256'd0);
    check("rst_digest", digest, 256'd0);
    check1("rst_digest_valid", digest_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // "abc" with junk in the unused byte; in_valid stays high afterwards.
    n_soc = 0; n_rst = 0;
    abc_block(); push_blk(blk); push_dig(1'b1, D_ABC);
    send_word(32'h616263FF, 3'd3, 1'b1);
    check1("busy_after_accept", busy, 1'b1);
    acc0 = n_acc;
    in_valid = 1'b1; in_data = 32'hDEADBEEF; in_nbytes = 3'd4;
    wait_done(500);
    check1("busy_at_digest_valid", busy, 1'b1);
    in_valid = 1'b0;
    checkn("no_accept_while_busy", n_acc - acc0, 0);
    @(negedge clk);
    check1("busy_after_done", busy, 1'b0);
    check1("in_ready_after_done", in_ready, 1'b1);
    check1("digest_valid_one_cycle", digest_valid, 1'b0);
    check("digest_held", digest, D_ABC);
    checkn("abc_core_rst_count", n_rst, 1);
    checkn("abc_core_soc_count", n_soc, 1);
    repeat (3) @(negedge clk);

    // Empty message.
    n_soc = 0; n_rst = 0;
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0] = 32'h80000000;
    push_blk(blk); push_dig(1'b1, D_EMPTY);
    send_word(32'h12345678, 3'd0, 1'b1);
    wait_done(500);
    checkn("empty_core_rst_count", n_rst, 1);
    checkn("empty_core_soc_count", n_soc, 1);
    repeat (3) @(negedge clk);

    // 56 bytes: marker and length spill into a second block.
    n_soc = 0; n_rst = 0;
    for (int i = 0; i < 14; i++) blk[i] = msg[i];
    blk[14] = 32'h80000000; blk[15] = '0;
    push_blk(blk);
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[15] = 32'h000001C0;
    push_blk(blk); push_dig(1'b1, D_448);
    for (int i = 0; i < 14; i++) send_word(msg[i], 3'd4, (i == 13));
    wait_done(800);
    checkn("b56_core_rst_count", n_rst, 1);
    checkn("b56_core_soc_count", n_soc, 2);
    repeat (3) @(negedge clk);

    // 55 bytes: marker in word 13, length fits in the same block.
    n_soc = 0; n_rst = 0;
    for (int i = 0; i < 13; i++) blk[i] = msg[i];
    blk[13] = 32'h6e6f7080; blk[14] = '0; blk[15] = 32'h000001B8;
    push_blk(blk); push_dig(1'b0, '0);
    for (int i = 0; i < 13; i++) send_word(msg[i], 3'd4, 1'b0);
    send_word(32'h6e6f70FF, 3'd3, 1'b1);
    wait_done(500);
    checkn("b55_core_rst_count", n_rst, 1);
    checkn("b55_core_soc_count", n_soc, 1);
    checkn("queues_drained", exp_words.size() + exp_dig.size(), 0);
    repeat (3) @(negedge clk);

    // Reset in the middle of SEND.
    ignore_words = 1'b1;
    dv0 = n_dv;
    send_word(32'h61626300, 3'd3, 1'b1);
    wait_soc(100);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_core_idata", {224'd0, core_idata}, 256'd0);
    check1("abort_core_soc", core_soc, 1'b0);
    check1("abort_core_rd", core_rd, 1'b0);
    check1("abort_core_rst", core_rst, 1'b0);
    check1("abort_busy", busy, 1'b0);
    check1("abort_in_ready", in_ready, 1'b1);
    check("abort_digest", digest, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    ignore_words = 1'b0;
    checkn("abort_no_digest_valid", n_dv - dv0, 0);

    n_soc = 0; n_rst = 0;
    abc_block(); push_blk(blk); push_dig(1'b1, D_ABC);
    send_word(32'h61626300, 3'd3, 1'b1);
    wait_done(500);
    checkn("restart_core_rst_count", n_rst, 1);
    repeat (3) @(negedge clk);

    // Core never signals completion.
    eoc_kill = 1'b1;
    dv0 = n_dv;
    abc_block(); push_blk(blk);
    send_word(32'h61626300, 3'd3, 1'b1);
    wait_soc(100);
    repeat (16) @(negedge clk);
    cnt = 0;
    while (!err && cnt < int'(TMO) + 60) begin @(negedge clk); cnt++; end
    checkn("timeout_cycles", cnt, int'(TMO) + 2);
    repeat (20) @(negedge clk);
    check1("err_sticky", err, 1'b1);
    check1("err_in_ready", in_ready, 1'b1);
    check1("err_busy", busy, 1'b0);
    check1("err_core_rd", core_rd, 1'b0);
    checkn("err_no_digest_valid", n_dv - dv0, 0);
    rst = 1'b1;
    @(negedge clk);
    check1("err_cleared_by_rst", err, 1'b0);
    rst = 1'b0;
    eoc_kill = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_feeder.md
SHA256_FEEDER -- requirements
Module: sha256_feeder

Interface
REQ-001 Parameter: EOC_TIMEOUT, default 127, max cycles to wait for core_eoc after a block is sent before flagging an error.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream message word valid.
REQ-005 in_ready  output  1  feeder accepts in_data this cycle.
REQ-006 in_data  input  32  message word, big-endian, first byte in [31:24].
REQ-007 in_nbytes  input  3  valid bytes in in_data (1..4), left-justified; 0 is legal only with in_last (empty final word).
REQ-008 in_last  input  1  final word of message.
REQ-009 core_rst  output  1  one-cycle reset pulse to the hash core at message start.
REQ-010 core_soc  output  1  one-cycle start-of-block pulse to the hash core.
REQ-011 core_idata  output  32  block word stream to the hash core.
REQ-012 core_rd  output  1  digest read enable to the hash core.
REQ-013 core_odata  input  32  digest word from the hash core.
REQ-014 core_eoc  input  1  hash core end-of-calculation.
REQ-015 digest  output  256  final hash, H0 in [255:224].
REQ-016 digest_valid  output  1  one-cycle pulse when digest is updated.
REQ-017 busy  output  1  high from first accepted word until digest_valid, inclusive.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 The block SHALL buffer one 16x32 block in internal storage; handshake transfer occurs when in_valid and in_ready are both high on a posedge.
REQ-020 States: IDLE, FILL, PAD, LEN, WAITC, CRST, SOC, SEND, WAITE, READ, DONE.
REQ-021 in_ready SHALL be high only in IDLE and FILL; a transfer in IDLE SHALL enter FILL.
REQ-022 Bytes beyond in_nbytes SHALL be masked to zero; a 64-bit byte counter SHALL accumulate in_nbytes; bit length = counter<<3, wrap modulo 2^64.
REQ-023 On in_last, the 0x80 byte SHALL be placed immediately after the last valid byte, in the same word if in_nbytes<4, otherwise in the next word.
REQ-024 PAD SHALL zero-fill words; if words 14-15 are free after 0x80 placement, LEN SHALL write bit length high word to 14, low word to 15; otherwise the block SHALL be zero-filled to word 15, sent, and a further block of 14 zero words plus length SHALL follow.
REQ-025 A full buffer (16 words) SHALL transition to WAITC; WAITC SHALL wait for core_eoc if a previous block of the same message is still computing, else proceed immediately.
REQ-026 For the first block of a message, CRST SHALL drive core_rst high for exactly one cycle before SOC.
REQ-027 SOC SHALL drive core_soc high for exactly one cycle; SEND SHALL present word 0 on core_idata in the cycle after core_soc and words 1..15 on the following 15 consecutive cycles; core_idata SHALL be zero otherwise.
REQ-028 After SEND of a non-final block the block SHALL return to FILL (buffer free, in_ready high) while the core computes.
REQ-029 After SEND of the final block, WAITE SHALL wait for core_eoc; then READ SHALL hold core_rd high for exactly 8 cycles, capturing core_odata at the k-th posedge into digest word Hk (k=0..7).
REQ-030 DONE SHALL pulse digest_valid for one cycle, clear byte counter and first-block flag, and return to IDLE; digest SHALL hold until the next digest_valid.
REQ-031 If core_eoc is not seen within EOC_TIMEOUT+1 cycles in WAITC or WAITE, err SHALL set, all core outputs SHALL drop, and state SHALL return to IDLE without digest_valid.
REQ-032 Latency for a single-block message: in_last accept to digest_valid = fill/pad cycles + 1 (CRST) + 1 (SOC) + 16 (SEND) + core compute + 8 (READ) + 1.

Reset
REQ-033 While rst is high, state=IDLE, in_ready=1, core_rst=core_soc=core_rd=0, core_idata=0, digest=0, digest_valid=0, busy=0, err=0, counters=0.
REQ-034 rst asserted mid-operation SHALL abort immediately with no digest_valid; the next message SHALL start with a fresh core_rst pulse.

Verification
REQ-035 "abc": 0x61626300, nbytes=3, last -> single block, W0=0x61626380, W1..W14=0, W15=0x00000018; with core model digest=ba7816bf...f20015ad.
REQ-036 Empty message: nbytes=0, last -> W0=0x80000000, W15=0; digest=e3b0c442...7852b855.
REQ-037 56 bytes (14 full words) -> two blocks; block1 W14=0x80000000, W15=0; block2 W0..W14=0, W15=0x000001C0; core_rst once, core_soc twice.
REQ-038 55 bytes (word 13 nbytes=3) -> one block, W13 low byte=0x80, W14=0, W15=0x000001B8.
REQ-039 in_valid held high during SEND/WAITE/READ -> no transfer (in_ready=0); rst pulsed mid-SEND -> all core outputs 0 next edge, busy=0, in_ready=1.
REQ-040 core_eoc tied low -> err=1 after EOC_TIMEOUT+1 cycles in WAITE, no digest_valid, err stays 1 until rst.
